// File: rtl/c_pipe_collector_if.sv
// c_pipe_collector_if
//   Bundles the collector's pipe-side inputs and consumer-side FIFO outputs.
//   master : driven by the environment (pipe enable, pipe sums, soft clear,
//            consumer ready); observes the FIFO head and status.
//   slave  : used by c_pipe_collector.
//   Signals: mac_en, clr, in_r, in_i, out_ready (toward collector);
//            out_r, out_i, out_valid, ovf, level, drop_cnt (from collector).
interface c_pipe_collector_if #(
  parameter int N     = 16,
  parameter int DEPTH = 4
);
  logic                      mac_en;
  logic                      clr;
  logic signed [N-1:0]       in_r;
  logic signed [N-1:0]       in_i;
  logic signed [N-1:0]       out_r;
  logic signed [N-1:0]       out_i;
  logic                      out_valid;
  logic                      out_ready;
  logic                      ovf;
  logic [$clog2(DEPTH):0]    level;
  logic [7:0]                drop_cnt;

  modport master (
    output mac_en, clr, in_r, in_i, out_ready,
    input  out_r, out_i, out_valid, ovf, level, drop_cnt
  );

  modport slave (
    input  mac_en, clr, in_r, in_i, out_ready,
    output out_r, out_i, out_valid, ovf, level, drop_cnt
  );
endinterface

// File: rtl/c_pipe_collector.sv
// c_pipe_collector
//   Output-side receiver for the complex MAC pipe. Delays the operand enable
//   by LAT cycles to know when the pipe sum contains a new product, captures
//   the sum once every 4 contiguous valid products, and queues the results in
//   a show-ahead FIFO with a valid/ready handshake.
//
//   Ports:
//     clk  - clock
//     rst  - synchronous active-high reset (also clears drop_cnt)
//     bus  - c_pipe_collector_if.slave: mac_en, clr, in_r, in_i, out_ready in;
//            out_r, out_i, out_valid, ovf, level, drop_cnt out
//
//   Build option: define C_PIPE_COLLECTOR_DROP_CNT_EN to enable the
//   saturating discarded-group counter; otherwise drop_cnt is tied to 0.
module c_pipe_collector #(
  parameter int N     = 16,
  parameter int Q     = 8,
  parameter int LAT   = 5,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  c_pipe_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LAT < 1 || Q < 0 || Q > N) begin : g_bad_param
    $error("c_pipe_collector: illegal parameter set");
  end

  logic [LAT-1:0]      en_dly_q, en_dly_d;
  logic [1:0]          grp_q, grp_d;
  logic [LW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic                ovf_q, ovf_d;
  logic signed [N-1:0] mem_r_q [DEPTH];
  logic signed [N-1:0] mem_i_q [DEPTH];

  logic          vd, valid, full, pop, push, accept, lost;
  logic [LW-1:0] level;

  // Stage boundary: pipe output alignment and group tracking
  assign vd     = en_dly_q[LAT-1];
  assign level  = wr_q - rd_q;
  assign valid  = (level != '0);
  assign full   = (level == LW'(DEPTH));
  assign pop    = valid && bus.out_ready;
  assign push   = vd && (grp_q == 2'd3);
  // A full FIFO still takes the new group when the head leaves on the same edge.
  assign accept = push && (!full || pop);
  assign lost   = push && full && !pop;

  always_comb begin
    en_dly_d    = en_dly_q << 1;
    en_dly_d[0] = bus.mac_en;
    // Incrementing past 3 wraps to 0, which is exactly the post-push state.
    grp_d       = vd ? grp_q + 2'd1 : 2'd0;
    wr_d        = wr_q + LW'(accept);
    rd_d        = rd_q + LW'(pop);
    ovf_d       = ovf_q | lost;
    if (bus.clr) begin
      en_dly_d = '0;
      grp_d    = '0;
      wr_d     = '0;
      rd_d     = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_dly_q <= '0;
      grp_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      en_dly_q <= en_dly_d;
      grp_q    <= grp_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      ovf_q    <= ovf_d;
    end
  end

  // Stage boundary: FIFO storage (data only, never reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_r_q[wr_q[AW-1:0]] <= bus.in_r;
      mem_i_q[wr_q[AW-1:0]] <= bus.in_i;
    end
  end

  // Head is forced to zero when empty so reset/clear show clean outputs
  // even though the storage itself is not reset.
  assign bus.out_r     = valid ? mem_r_q[rd_q[AW-1:0]] : '0;
  assign bus.out_i     = valid ? mem_i_q[rd_q[AW-1:0]] : '0;
  assign bus.out_valid = valid;
  assign bus.level     = level;
  assign bus.ovf       = ovf_q;

`ifdef C_PIPE_COLLECTOR_DROP_CNT_EN
  logic       brk;
  logic [7:0] drop_q, drop_d;

  assign brk = !vd && (grp_q != 2'd0);

  always_comb begin
    drop_d = drop_q;
    if (!bus.clr && (brk || lost) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign bus.drop_cnt = drop_q;
`else
  assign bus.drop_cnt = 8'd0;
`endif
endmodule
